cam_cfg_sequencer: RTL and testbench

//  Walks a camera register table (16-bit {reg,val} entries in external sync ROM) and issues
//  one SCCB write per entry to the SCCB master via valid/ready, then waits for completion.

---
 rtl/cam_cfg_sequencer_pkg.sv | 26 ++
 rtl/cam_cfg_sequencer_if.sv | 22 ++
 rtl/cam_cfg_sequencer_ms_timer.sv | 51 +++++
 rtl/cam_cfg_sequencer.sv | 120 ++++++++++++
 tb/tb_cam_cfg_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_cfg_sequencer_pkg.sv
// Shared constants for the camera register-table sequencer.
// Entry markers, FSM state codes and entry decode helpers.
package cam_cfg_sequencer_pkg;

    localparam logic [15:0] CFG_EOT      = 16'hFFFF;
    localparam logic [7:0]  CFG_DELAY_OP = 8'hF0;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_SEND     = 4'd3;
    localparam logic [3:0] ST_WAIT_ACK = 4'd4;
    localparam logic [3:0] ST_DELAY    = 4'd5;
    localparam logic [3:0] ST_NEXT     = 4'd6;
    localparam logic [3:0] ST_DONE     = 4'd7;
    localparam logic [3:0] ST_ERROR    = 4'd8;

    function automatic logic is_eot(input logic [15:0] e);
        return e == CFG_EOT;
    endfunction

    function automatic logic is_delay(input logic [15:0] e);
        return e[15:8] == CFG_DELAY_OP;
    endfunction

endpackage

// File: rtl/cam_cfg_sequencer_if.sv
// SCCB write-request channel between the sequencer and the SCCB master.
// Request handshake on valid/ready, completion reported by done/nack pulses.
interface cam_cfg_sequencer_if;

    logic       valid;
    logic       ready;
    logic [7:0] reg_addr;
    logic [7:0] reg_val;
    logic       done;
    logic       nack;

    modport master (
        output valid, reg_addr, reg_val,
        input  ready, done, nack
    );

    modport slave (
        input  valid, reg_addr, reg_val,
        output ready, done, nack
    );

endinterface

// File: rtl/cam_cfg_sequencer_ms_timer.sv
// Millisecond delay timer for in-table delay entries.
// A load of N ms pulses expired once after N ms; a load of 0 pulses next cycle.
module cam_cfg_sequencer_ms_timer #(
    parameter int CLK_FREQ = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] ms,
    output logic       expired
);

    localparam int TICKS = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
    localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS - 1);

    logic [TW-1:0] tick_cnt;
    logic [7:0]    ms_cnt;
    logic          active;

    // Count ticks within a millisecond and milliseconds down to expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
            active   <= 1'b0;
            expired  <= 1'b0;
        end else begin
            expired <= 1'b0;
            if (load) begin
                tick_cnt <= '0;
                ms_cnt   <= ms;
                active   <= (ms != 8'd0);
                expired  <= (ms == 8'd0);
            end else if (active) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    if (ms_cnt == 8'd1) begin
                        active  <= 1'b0;
                        expired <= 1'b1;
                    end else begin
                        ms_cnt <= ms_cnt - 8'd1;
                    end
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Walks a {reg,val} table in sync ROM and issues one SCCB write per entry.
// Handles delay entries, end-of-table marker and bounded NACK retry.
module cam_cfg_sequencer
    import cam_cfg_sequencer_pkg::*;
#(
    parameter int CLK_FREQ  = 25_000_000,
    parameter int ROM_AW    = 7,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    cam_cfg_sequencer_if.master sccb,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ROM_AW-1:0] err_addr
);

    localparam logic [ROM_AW-1:0] LAST  = '1;
    localparam logic [7:0]        LIMIT = 8'(MAX_RETRY);

    logic [3:0]        state;
    logic [ROM_AW-1:0] addr;
    logic [7:0]        retry;
    logic [7:0]        reg_q;
    logic [7:0]        val_q;
    logic              tmr_load;
    logic              expired;

    assign tmr_load = (state == ST_DECODE)
                    && !is_eot(rom_data)
                    && is_delay(rom_data);

    cam_cfg_sequencer_ms_timer #(
        .CLK_FREQ (CLK_FREQ)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .ms      (rom_data[7:0]),
        .expired (expired)
    );

    // Sequencer FSM: fetch, decode, send/retry or delay, advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            retry    <= '0;
            reg_q    <= '0;
            val_q    <= '0;
            err_addr <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        addr  <= '0;
                        retry <= '0;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    if (is_eot(rom_data)) begin
                        state <= ST_DONE;
                    end else if (is_delay(rom_data)) begin
                        state <= ST_DELAY;
                    end else begin
                        reg_q <= rom_data[15:8];
                        val_q <= rom_data[7:0];
                        state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sccb.ready) state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (sccb.nack) begin
                        if (retry < LIMIT) begin
                            retry <= retry + 8'd1;
                            state <= ST_SEND;
                        end else begin
                            err_addr <= addr;
                            state    <= ST_ERROR;
                        end
                    end else if (sccb.done) begin
                        state <= ST_NEXT;
                    end
                end
                ST_DELAY: begin
                    if (expired) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    retry <= '0;
                    if (addr == LAST) begin
                        state <= ST_DONE;
                    end else begin
                        addr  <= addr + 1'b1;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rom_addr      = addr;
    assign sccb.valid    = (state == ST_SEND);
    assign sccb.reg_addr = reg_q;
    assign sccb.reg_val  = val_q;
    assign busy = !(state == ST_IDLE
                 || state == ST_DONE
                 || state == ST_ERROR);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERROR);

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer with a sync ROM and SCCB responder.
// Small table depth (8) and 1 kHz clock so delays are one cycle per ms.
module tb_cam_cfg_sequencer;

    localparam int AW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic          busy;
    logic          seq_done;
    logic          err;
    logic [AW-1:0] err_addr;

    logic [15:0] rom [8];

    cam_cfg_sequencer_if bus();

    cam_cfg_sequencer #(
        .CLK_FREQ  (1000),
        .ROM_AW    (AW),
        .MAX_RETRY (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sccb     (bus),
        .busy     (busy),
        .done     (seq_done),
        .err      (err),
        .err_addr (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model: data one cycle after address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    int checks = 0;
    int errors = 0;

    int         acc_cnt = 0;
    logic [7:0] acc_reg [16];
    logic [7:0] acc_val [16];
    int         nack_left = 0;
    int         resp_dly = 10;
    bit         resp_en = 1'b1;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SCCB responder: record accepted requests, answer after resp_dly.
    initial begin
        bus.done = 1'b0;
        bus.nack = 1'b0;
        forever begin
            if (!(bus.valid === 1'b1 && bus.ready === 1'b1)) begin
                @(negedge clk);
            end else begin
                if (acc_cnt < 16) begin
                    acc_reg[acc_cnt] = bus.reg_addr;
                    acc_val[acc_cnt] = bus.reg_val;
                end
                acc_cnt++;
                if (resp_en) begin
                    repeat (resp_dly) @(negedge clk);
                    if (nack_left > 0) begin
                        nack_left--;
                        bus.nack = 1'b1;
                    end else begin
                        bus.done = 1'b1;
                    end
                    @(negedge clk);
                    bus.nack = 1'b0;
                    bus.done = 1'b0;
                end else begin
                    @(negedge clk);
                end
            end
        end
    end

    task automatic fill_eot();
        for (int i = 0; i < 8; i++) rom[i] = 16'hFFFF;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #1 bus.ready = r;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic time_to_done(output int n);
        n = 0;
        while (!seq_done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int  t0;
        int  t10;
        int  n;
        int  same;
        logic [7:0] r0;
        logic [7:0] v0;
        bit  stable;

        rst = 1'b1;
        start = 1'b0;
        bus.ready = 1'b1;
        fill_eot();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(seq_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'd0);
        check("rst_erraddr", 32'(err_addr), 32'd0);
        check("rst_reg", 32'(bus.reg_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Two writes then end marker
        rom[0] = 16'h1280;
        rom[1] = 16'h1101;
        rom[2] = 16'hFFFF;
        acc_cnt = 0;
        resp_dly = 10;
        pulse_start();
        check("t1_fetch_busy", 32'(busy), 32'd1);
        check("t1_fetch_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);
        check("t1_decode_valid", 32'(bus.valid), 32'd0);
        @(negedge clk);
        check("t1_send_valid", 32'(bus.valid), 32'd1);
        check("t1_send_reg", 32'(bus.reg_addr), 32'h12);
        check("t1_send_val", 32'(bus.reg_val), 32'h80);
        wait_idle("t1_timeout");
        check("t1_count", 32'(acc_cnt), 32'd2);
        check("t1_reg1", 32'(acc_reg[1]), 32'h11);
        check("t1_val1", 32'(acc_val[1]), 32'h01);
        check("t1_done", 32'(seq_done), 32'd1);
        check("t1_err", 32'(err), 32'd0);

        // Delay entries: 10 ms vs 0 ms must differ by 10 cycles
        fill_eot();
        rom[0] = 16'hF000;
        acc_cnt = 0;
        pulse_start();
        time_to_done(t0);
        rom[0] = 16'hF00A;
        pulse_start();
        time_to_done(t10);
        check("t2_done", 32'(seq_done), 32'd1);
        check("t2_delay_window",
              32'((t10 - t0 >= 10) && (t10 - t0 <= 11)), 32'd1);
        check("t2_no_valid", 32'(acc_cnt), 32'd0);

        // NACK x3 then ACK: four identical sends, then next entry
        fill_eot();
        rom[0] = 16'h3A04;
        rom[1] = 16'h1234;
        acc_cnt = 0;
        nack_left = 3;
        resp_dly = 2;
        pulse_start();
        wait_idle("t3_timeout");
        check("t3_count", 32'(acc_cnt), 32'd5);
        same = 0;
        for (int i = 0; i < 4; i++)
            if (acc_reg[i] == 8'h3A && acc_val[i] == 8'h04) same++;
        check("t3_repeats", 32'(same), 32'd4);
        check("t3_next_reg", 32'(acc_reg[4]), 32'h12);
        check("t3_next_val", 32'(acc_val[4]), 32'h34);
        check("t3_done", 32'(seq_done), 32'd1);

        // NACK x4 at address 5: error, no fifth request
        fill_eot();
        for (int i = 0; i < 5; i++) rom[i] = 16'hF000;
        rom[5] = 16'h3A04;
        acc_cnt = 0;
        nack_left = 4;
        pulse_start();
        wait_idle("t4_timeout");
        repeat (20) @(negedge clk);
        check("t4_err", 32'(err), 32'd1);
        check("t4_err_addr", 32'(err_addr), 32'd5);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_done", 32'(seq_done), 32'd0);
        check("t4_count", 32'(acc_cnt), 32'd4);

        // Back-pressure with a start pulse during the sequence
        fill_eot();
        rom[0] = 16'h5566;
        acc_cnt = 0;
        nack_left = 0;
        set_ready(1'b0);
        pulse_start();
        check("t5_err_clr", 32'(err), 32'd0);
        n = 0;
        while (bus.valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid_seen", 32'(bus.valid), 32'd1);
        r0 = bus.reg_addr;
        v0 = bus.reg_val;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = (i == 5);
            if (!(bus.valid === 1'b1 && bus.reg_addr === r0
                  && bus.reg_val === v0 && rom_addr === '0
                  && busy === 1'b1))
                stable = 1'b0;
        end
        start = 1'b0;
        check("t5_stable", 32'(stable), 32'd1);
        check("t5_reg", 32'(r0), 32'h55);
        check("t5_val", 32'(v0), 32'h66);
        set_ready(1'b1);
        wait_idle("t5_timeout");
        check("t5_count", 32'(acc_cnt), 32'd1);
        check("t5_done", 32'(seq_done), 32'd1);

        // Reset while waiting for ACK, then a stray done pulse
        fill_eot();
        rom[0] = 16'h7788;
        acc_cnt = 0;
        resp_en = 1'b0;
        pulse_start();
        n = 0;
        while (acc_cnt < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("t6_in_wait", 32'({busy, bus.valid}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.done = 1'b1;
        @(negedge clk);
        bus.done = 1'b0;
        @(negedge clk);
        check("t6_outputs",
              32'({busy, seq_done, err, bus.valid}), 32'd0);
        check("t6_regval",
              32'({bus.reg_addr, bus.reg_val}), 32'd0);
        check("t6_addr", 32'(rom_addr), 32'd0);
        resp_en = 1'b1;
        resp_dly = 3;
        pulse_start();
        check("t6_refetch", 32'({busy, rom_addr}), 32'({1'b1, 3'd0}));
        wait_idle("t6_timeout");
        check("t6_count", 32'(acc_cnt), 32'd2);
        check("t6_last", 32'({acc_reg[1], acc_val[1]}), 32'h7788);
        check("t6_done", 32'(seq_done), 32'd1);

        // Full table with no end marker finishes at the last address
        for (int i = 0; i < 8; i++)
            rom[i] = {8'h20 + 8'(i), 8'(i)};
        acc_cnt = 0;
        pulse_start();
        wait_idle("t7_timeout");
        check("t7_count", 32'(acc_cnt), 32'd8);
        check("t7_last_reg", 32'(acc_reg[7]), 32'h27);
        check("t7_done", 32'(seq_done), 32'd1);
        check("t7_no_wrap", 32'(rom_addr), 32'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
